rf_rd_arb: RTL

RF_RD_ARB -- requirements
Module: rf_rd_arb

---
 rtl/rf_rd_arb.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rf_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module   : rf_rd_arb
//  Purpose  : Two-requester round-robin register-file read arbiter with
//             zero-register shortcut, WAIT timeout and sticky error flag.
//  Revision : 1.0  initial release
// ============================================================================
module rf_rd_arb #(
    parameter int WIDTH        = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int TIMEOUT      = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    r0_req,
    input  logic [REG_ADDR_LEN-1:0] r0_add,
    output logic [WIDTH-1:0]        r0_data,
    output logic                    r0_done,
    input  logic                    r1_req,
    input  logic [REG_ADDR_LEN-1:0] r1_add,
    output logic [WIDTH-1:0]        r1_data,
    output logic                    r1_done,
    output logic [REG_ADDR_LEN-1:0] rf_add,
    output logic                    rf_en,
    input  logic [WIDTH-1:0]        rf_data,
    input  logic                    rf_st,
    output logic                    busy,
    output logic                    err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

    state_t                  r_state, w_state_nxt;
    logic                    r_ptr, w_ptr_nxt;
    logic                    r_gnt, w_gnt_nxt;
    logic [REG_ADDR_LEN-1:0] r_addr, w_addr_nxt;
    logic [7:0]              r_cnt, w_cnt_nxt;

    logic [REG_ADDR_LEN-1:0] w_rf_add_nxt;
    logic                    w_rf_en_nxt;
    logic [WIDTH-1:0]        w_r0_data_nxt, w_r1_data_nxt;
    logic                    w_r0_done_nxt, w_r1_done_nxt;
    logic                    w_err_nxt;
    logic                    w_sel;
    logic                    w_resp;
    logic [WIDTH-1:0]        w_resp_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b0;
            r_gnt   <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= '0;
            rf_add  <= '0;
            rf_en   <= 1'b0;
            r0_data <= '0;
            r1_data <= '0;
            r0_done <= 1'b0;
            r1_done <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            rf_add  <= w_rf_add_nxt;
            rf_en   <= w_rf_en_nxt;
            r0_data <= w_r0_data_nxt;
            r1_data <= w_r1_data_nxt;
            r0_done <= w_r0_done_nxt;
            r1_done <= w_r1_done_nxt;
            busy    <= (w_state_nxt != S_IDLE);
            err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gnt_nxt     = r_gnt;
        w_addr_nxt    = r_addr;
        w_cnt_nxt     = r_cnt;
        w_rf_add_nxt  = rf_add;
        w_rf_en_nxt   = rf_en;
        w_r0_data_nxt = r0_data;
        w_r1_data_nxt = r1_data;
        w_r0_done_nxt = 1'b0;
        w_r1_done_nxt = 1'b0;
        w_err_nxt     = err;
        w_sel         = 1'b0;
        w_resp        = 1'b0;
        w_resp_data   = '0;

        case (r_state)
            S_IDLE: begin
                if (r0_req || r1_req) begin
                    // Contention goes to the favoured requester; a lone request always wins.
                    w_sel       = (r0_req && r1_req) ? r_ptr : r1_req;
                    w_gnt_nxt   = w_sel;
                    w_ptr_nxt   = ~w_sel;
                    w_addr_nxt  = w_sel ? r1_add : r0_add;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT;
                    if (w_addr_nxt != '0) begin
                        w_rf_add_nxt = w_addr_nxt;
                        w_rf_en_nxt  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Register 0 is hard-wired to zero, so it never touches the RF.
                if (r_addr == '0) begin
                    w_resp = 1'b1;
                end else if (rf_st) begin
                    w_resp      = 1'b1;
                    w_resp_data = rf_data;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_resp    = 1'b1;
                    w_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_resp) begin
            w_state_nxt = S_RESP;
            w_rf_en_nxt = 1'b0;
            if (r_gnt) begin
                w_r1_data_nxt = w_resp_data;
                w_r1_done_nxt = 1'b1;
            end else begin
                w_r0_data_nxt = w_resp_data;
                w_r0_done_nxt = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
